// File: rtl/fft_peak_reader.sv
// Peak-magnitude bin finder over FFT frames; FFT_PEAK_SKIP_DC_EN excludes bin 0 from the search.
// Latency: peak_valid rises 3 cycles after the frame-closing beat is accepted.
// Backpressure: tready drops once a frame closes and stays low until its result is consumed.
module fft_peak_reader #(
  parameter int FRAME_LEN = 1024,
  parameter int DATA_W    = 24,
  parameter int IDX_W     = 10
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] s_axis_data_tdata_re,
  input  logic signed [DATA_W-1:0] s_axis_data_tdata_im,
  input  logic                     s_axis_data_tvalid,
  input  logic                     s_axis_data_tlast,
  output logic                     s_axis_data_tready,
  output logic [IDX_W-1:0]         peak_bin,
  output logic [2*DATA_W-1:0]      peak_mag,
  output logic                     peak_valid,
  input  logic                     peak_ready,
  output logic                     err_tlast_unexpected,
  output logic                     err_tlast_missing
);

  localparam int MAG_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0]         bin_cnt;
  logic                     accept, at_last, closing, consume, pending, pending_nxt;

  logic                     s1_vld, s1_close;
  logic signed [DATA_W-1:0] s1_re, s1_im;
  logic [IDX_W-1:0]         s1_idx;

  logic                     s2_vld, s2_close;
  logic [MAG_W-1:0]         s2_mag;
  logic [IDX_W-1:0]         s2_idx;

  logic [MAG_W-1:0]         run_mag, base_mag, new_mag;
  logic [IDX_W-1:0]         run_idx, base_idx, new_idx;
  logic                     cand_ok;

  logic signed [MAG_W-1:0]  re_ext, im_ext;
  logic [MAG_W-1:0]         sq_sum;

  assign accept  = s_axis_data_tvalid && s_axis_data_tready;
  assign at_last = (bin_cnt == LAST_BIN);
  assign closing = s_axis_data_tlast || at_last;
  assign consume = peak_valid && peak_ready;

  // A closed frame stays pending from close until its result is taken.
  assign pending_nxt = (pending && !consume) || (accept && closing);

  assign re_ext = MAG_W'(s1_re);
  assign im_ext = MAG_W'(s1_im);
  assign sq_sum = re_ext * re_ext + im_ext * im_ext;

  // Bin 0 always opens a frame, so it seeds the running max from zero.
  always_comb begin
    base_mag = run_mag;
    base_idx = run_idx;
    new_mag  = run_mag;
    new_idx  = run_idx;
    if (s2_idx == '0) begin
      base_mag = '0;
      base_idx = '0;
    end
`ifdef FFT_PEAK_SKIP_DC_EN
    cand_ok = (s2_idx != '0);
`else
    cand_ok = 1'b1;
`endif
    if (cand_ok && (s2_mag > base_mag)) begin
      new_mag = s2_mag;
      new_idx = s2_idx;
    end else begin
      new_mag = base_mag;
      new_idx = base_idx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      bin_cnt              <= '0;
      s1_vld               <= 1'b0;
      s1_close             <= 1'b0;
      s1_re                <= '0;
      s1_im                <= '0;
      s1_idx               <= '0;
      s2_vld               <= 1'b0;
      s2_close             <= 1'b0;
      s2_mag               <= '0;
      s2_idx               <= '0;
      run_mag              <= '0;
      run_idx              <= '0;
      pending              <= 1'b0;
      s_axis_data_tready   <= 1'b0;
      peak_valid           <= 1'b0;
      peak_bin             <= '0;
      peak_mag             <= '0;
      err_tlast_unexpected <= 1'b0;
      err_tlast_missing    <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_re    <= s_axis_data_tdata_re;
        s1_im    <= s_axis_data_tdata_im;
        s1_idx   <= bin_cnt;
        s1_close <= closing;
        bin_cnt  <= closing ? '0 : bin_cnt + IDX_W'(1);
      end
      err_tlast_unexpected <= accept && s_axis_data_tlast && !at_last;
      err_tlast_missing    <= accept && !s_axis_data_tlast && at_last;

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_mag   <= sq_sum;
        s2_idx   <= s1_idx;
        s2_close <= s1_close;
      end

      if (s2_vld) begin
        run_mag <= new_mag;
        run_idx <= new_idx;
      end

      if (consume) begin
        peak_valid <= 1'b0;
        peak_bin   <= '0;
        peak_mag   <= '0;
      end
      if (s2_vld && s2_close) begin
        peak_valid <= 1'b1;
        peak_bin   <= new_idx;
        peak_mag   <= new_mag;
      end

      pending            <= pending_nxt;
      s_axis_data_tready <= !pending_nxt;
    end
  end

endmodule

// File: doc/fft_peak_reader.md
FFT_PEAK_READER -- requirements
Module: fft_peak_reader

Interface
REQ-001 Parameter FRAME_LEN, default 1024: number of FFT output beats per frame (power of two).
REQ-002 Parameter DATA_W, default 24: width of each signed FFT output component.
REQ-003 Parameter IDX_W, default 10: bin index width, equal to log2(FRAME_LEN).
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 s_axis_data_tdata_re  input  DATA_W  signed real part of the FFT output beat.
REQ-008 s_axis_data_tdata_im  input  DATA_W  signed imaginary part of the FFT output beat.
REQ-009 s_axis_data_tvalid  input  1  FFT output beat valid.
REQ-010 s_axis_data_tlast  input  1  last beat of the FFT frame.
REQ-011 s_axis_data_tready  output  1  block accepts a beat.
REQ-012 peak_bin  output  IDX_W  bin index of the maximum-magnitude beat in the completed frame.
REQ-013 peak_mag  output  2*DATA_W  unsigned re*re + im*im of that beat.
REQ-014 peak_valid  output  1  peak_bin and peak_mag hold a result.
REQ-015 peak_ready  input  1  consumer takes the result.
REQ-016 err_tlast_unexpected  output  1  one-cycle pulse: tlast seen before bin FRAME_LEN-1.
REQ-017 err_tlast_missing  output  1  one-cycle pulse: bin FRAME_LEN-1 accepted without tlast.

Function
REQ-018 Beat acceptance SHALL occur only in cycles where s_axis_data_tvalid and s_axis_data_tready are both 1.
REQ-019 A bin counter SHALL start at 0, increment on each accepted beat, and return to 0 after the frame-closing beat.
REQ-020 A frame SHALL close on an accepted beat with tlast=1, or on an accepted beat with counter = FRAME_LEN-1, whichever comes first.
REQ-021 Magnitude SHALL be computed as the full-precision sign-extended squares sum, 2*DATA_W bits, with no truncation or saturation.
REQ-022 The pipeline SHALL have two stages: stage 1 registers re, im, index, and close flag; stage 2 registers the squares sum and performs the compare.
REQ-023 The running maximum SHALL update only on strictly greater magnitude, so the lowest index wins on ties.
REQ-024 peak_valid SHALL rise exactly 3 clk_in cycles after acceptance of the frame-closing beat.
REQ-025 The result SHALL be held stable while peak_valid=1 and peak_ready=0, and cleared on the cycle after peak_valid and peak_ready are both 1.
REQ-026 s_axis_data_tready SHALL be 0 while a result is pending and unconsumed; otherwise it SHALL be 1. Frames therefore never overwrite an unread result.
REQ-027 When tlast is accepted at counter < FRAME_LEN-1, err_tlast_unexpected SHALL pulse; the frame still closes and a result is still reported.
REQ-028 When counter = FRAME_LEN-1 is accepted with tlast=0, err_tlast_missing SHALL pulse; the frame still closes and the counter wraps to 0.
REQ-029 Error pulses SHALL be asserted in the cycle after the offending beat is accepted.
REQ-030 A peak_ready handshake and a new beat acceptance in the same cycle SHALL both take effect.
REQ-031 The running maximum of the next frame SHALL start fresh and be independent of the pending result.

Reset
REQ-032 With rst_n=0 at a clock edge, all of the following SHALL be cleared:
- peak_valid = 0, peak_bin = 0, peak_mag = 0;
- err_tlast_unexpected = 0, err_tlast_missing = 0;
- bin counter, pipeline valids and running maximum = 0.
REQ-033 s_axis_data_tready SHALL be 0 during reset and 1 in the first cycle after release.
REQ-034 Reset mid-frame SHALL discard the partial frame; the first beat after release is bin 0.

Configuration
REQ-035 Macro FFT_PEAK_SKIP_DC_EN: when defined, bin 0 SHALL be excluded from the search, the reported peak is the maximum over bins 1..FRAME_LEN-1, and a frame closed at bin 0 reports peak_bin=0 and peak_mag=0.
REQ-036 When FFT_PEAK_SKIP_DC_EN is undefined, bin 0 SHALL participate like any other bin.

Verification
REQ-037 Full frame, all beats zero except bin 37 (re=1000, im=-500) -> peak_bin=37, peak_mag=1250000, peak_valid 3 cycles after tlast, no error pulses.
REQ-038 Bins 5 and 9 both (re=300, im=400) -> peak_bin=5, peak_mag=250000.
REQ-039 tlast at bin 99 -> err_tlast_unexpected pulses once, result reported, next beat counted as bin 0.
REQ-040 1024 beats with no tlast -> err_tlast_missing pulses once, result reported, counter wraps.
REQ-041 peak_ready=0 for 20 cycles after result -> tready=0 and result stable throughout; peak_ready=1 -> result cleared and tready=1 next cycle.
REQ-042 Bin 0 (re=-8388608, im=0) largest, bin 3 (re=100) next -> without macro peak_bin=0, peak_mag=2^46; with FFT_PEAK_SKIP_DC_EN peak_bin=3, peak_mag=10000.
